vdp_sprite_display_ex: RTL
==========================

// Module: vdp_sprite_display_ex
// PURPOSE
//  Parametrised sprite line-buffer display stage for the VDP. Each dot it reads the
//  sprite line buffer (2 pixels/word, even/odd halves), selects the pixel for the current
//  screen X with fine scroll and optional x2 magnify, drives the sprite colour to the mixer
//  and clears consumed words for the next line. Sits between sprite render and colour mixer.
// PARAMETERS
//  COLOR_W   4    colour code width; buffer entry = {valid, cc, colour[COLOR_W-1:0]}
//  ADR_W     7    line-buffer word address width (2^(ADR_W+1) pixels per line)
//  H_ACTIVE  256  active dots per line; pixels at X >= H_ACTIVE are never shown or cleared
//  SCROLL_W  3    fine horizontal scroll width
//  LINE_END  341  last dot_counter_x value of a line (counter then wraps to 9'h1FF)
// PORTS
//  clk21m                   in   1          system clock, 21.48 MHz
//  reset_n                  in   1          asynchronous reset, active low
//  dot_state                in   2          dot phase, sequence 00->01->11->10
//  dot_counter_x            in   9          dot X; increments at dot_state 11
//  reg_h_scroll             in   SCROLL_W   fine scroll, pixel index = X - scroll
//  reg_sp_mag_x             in   1          1: each buffer pixel shown for 2 dots
//  reg_sp_disable           in   1          1: sprite output forced off (erase continues)
//  reg_erase_en             in   1          1: write-back clearing enabled
//  line_buffer_display_adr  out  ADR_W      word address to line buffer
//  line_buffer_display_we   out  1          write strobe, 1 clock
//  line_buffer_display_d    out  COLOR_W+2  write data, always 0 (clear)
//  line_buffer_xeven_q      in   COLOR_W+2  even-pixel half of addressed word, 1 clk latency
//  line_buffer_xodd_q       in   COLOR_W+2  odd-pixel half of addressed word, 1 clk latency
//  sp_color_out             out  1          sprite pixel present at this dot
//  sp_color_code            out  COLOR_W    sprite colour
//  sp_cc_flag               out  1          colour-combine flag of pixel
//  sp_display_en            out  1          current dot inside active window
// BEHAVIOUR
//  - Reset (reset_n=0, async): all outputs 0, latched scroll/mag 0. After release, first
//    fetch at next dot_state 00.
//  - Line latch: at dot_state 00 with dot_counter_x==9'h1FF, sample reg_h_scroll and
//    reg_sp_mag_x; held constant for the whole line (mid-line writes take effect next line).
//  - Pixel index p (ADR_W+1 bits, mod 2^(ADR_W+1)): p = X - scroll; mag: p = (X - scroll)>>1.
//    Active = (X < H_ACTIVE) evaluated on dot_counter_x (unsigned).
//  - Per dot, X = dot_counter_x during phases 00/01:
//      00: register adr = p[ADR_W:1]; record sel = p[0], active, last.
//      01: buffer q valid.
//      11: if active: sp_color_code = sel ? odd[COLOR_W-1:0] : even[...];
//          sp_cc_flag = entry[COLOR_W]; sp_color_out = entry[COLOR_W+1] & ~reg_sp_disable;
//          sp_display_en = 1. If not active: all four outputs 0. Outputs hold 4 clocks.
//      10: we = 1 for exactly this clock iff active & reg_erase_en & last, adr unchanged,
//          d = 0. last = (sel==1) and, in mag mode, (X - scroll)[0]==1.
//  - Latency: screen dot X appears on outputs from its dot_state 11 to next 11 (fixed).
//  - Wrap: p wraps mod line-buffer size; scroll > X addresses top of buffer, legal.
//  - Counter wrap LINE_END -> 9'h1FF: inactive, no read use, no write.
//  - Unknown dot_state (impossible) treated as 10 without write.
//  - Reset asserted mid-write: we drops immediately (async); no partial state survives.
// TESTING
//  1 Buffer models q = {2'b10, adr[1:0], half}; scroll 0, mag 0: dots 0..7 give colours
//    0,1,2,3,4,5,6,7, sp_color_out=1, we pulses at phase 10 of dots 1,3,5,7 only.
//  2 Scroll 3, mag 0: dot 3 shows pixel 0 colour 0; dot 0 shows pixel 2^(ADR_W+1)-3
//    (wrap), colour 5 for ADR_W=7.
//  3 Mag 1, scroll 0: dots 0,1 colour 0; dots 2,3 colour 1; we only at dots 3,7,11,...
//  4 X = 256..341: sp_display_en=0, sp_color_out=0, colour 0, zero we pulses.
//  5 reg_sp_disable=1, erase_en=1: sp_color_out=0 all line, colours still driven,
//    we pattern as test 1; erase_en=0 -> no we ever.
//  6 Change scroll mid-line to 5: no effect until next line; reset_n low at phase 10 of
//    dot 5 -> we and all outputs 0 same clock, normal output resumes next line.

Source files
------------

// File: rtl/vdp_sprite_display_ex_if.sv
// rtl/vdp_sprite_display_ex_if.sv - sprite line-buffer display port bundle
//
// Purpose: carries the display-side read/clear port of the sprite line buffer.
//   Every addressed word holds two pixels (even/odd halves); each half is
//   {valid, cc, colour[COLOR_W-1:0]}.
// Signals:
//   line_buffer_display_adr  word address driven by the display stage
//   line_buffer_display_we   one-clock clear strobe
//   line_buffer_display_d    write data (always zero, clears the word)
//   line_buffer_xeven_q      even-pixel half of the addressed word, 1 clk latency
//   line_buffer_xodd_q       odd-pixel half of the addressed word, 1 clk latency
// Modports: master = display stage, slave = line buffer RAM.
interface vdp_sprite_display_ex_if #(
  parameter int COLOR_W = 4,
  parameter int ADR_W   = 7
);
  logic [ADR_W-1:0]   line_buffer_display_adr;
  logic               line_buffer_display_we;
  logic [COLOR_W+1:0] line_buffer_display_d;
  logic [COLOR_W+1:0] line_buffer_xeven_q;
  logic [COLOR_W+1:0] line_buffer_xodd_q;

  modport master (
    output line_buffer_display_adr,
    output line_buffer_display_we,
    output line_buffer_display_d,
    input  line_buffer_xeven_q,
    input  line_buffer_xodd_q
  );

  modport slave (
    input  line_buffer_display_adr,
    input  line_buffer_display_we,
    input  line_buffer_display_d,
    output line_buffer_xeven_q,
    output line_buffer_xodd_q
  );
endinterface

// File: rtl/vdp_sprite_display_ex.sv
// rtl/vdp_sprite_display_ex.sv - sprite line-buffer display stage
//
// Purpose: once per dot, reads the sprite line buffer at the pixel for the
//   current screen X (fine scroll, optional x2 magnify), drives the sprite
//   colour to the mixer and clears each word once both of its pixels have
//   been consumed, so the buffer is empty for the next rendered line.
// Ports:
//   clk21m, reset_n          clock, asynchronous active-low reset
//   dot_state                dot phase 00 -> 01 -> 11 -> 10
//   dot_counter_x            screen X of the current dot
//   reg_h_scroll             fine horizontal scroll (latched per line)
//   reg_sp_mag_x             x2 horizontal magnify (latched per line)
//   reg_sp_disable           suppress sprite visibility (clearing continues)
//   reg_erase_en             enable write-back clearing
//   lb                       line-buffer port (master side)
//   sp_color_out             sprite pixel present at this dot
//   sp_color_code            sprite colour
//   sp_cc_flag               colour-combine flag
//   sp_display_en            dot lies inside the active window
module vdp_sprite_display_ex #(
  parameter int COLOR_W  = 4,
  parameter int ADR_W    = 7,
  parameter int H_ACTIVE = 256,
  parameter int SCROLL_W = 3,
  parameter int LINE_END = 341
) (
  input  logic                     clk21m,
  input  logic                     reset_n,
  input  logic [1:0]               dot_state,
  input  logic [8:0]               dot_counter_x,
  input  logic [SCROLL_W-1:0]      reg_h_scroll,
  input  logic                     reg_sp_mag_x,
  input  logic                     reg_sp_disable,
  input  logic                     reg_erase_en,
  vdp_sprite_display_ex_if.master  lb,
  output logic                     sp_color_out,
  output logic [COLOR_W-1:0]       sp_color_code,
  output logic                     sp_cc_flag,
  output logic                     sp_display_en
);

  localparam int PIX_W = ADR_W + 1;  // pixel index width
  localparam int DIF_W = PIX_W + 1;  // one extra bit so magnify can shift it away

  localparam logic [1:0] PH_FETCH = 2'b00;
  localparam logic [1:0] PH_READ  = 2'b01;
  localparam logic [1:0] PH_SHOW  = 2'b11;
  localparam logic [1:0] PH_ERASE = 2'b10;

  localparam logic [9:0] H_ACT_X = 10'(H_ACTIVE);
  localparam logic [9:0] LAST_X  = 10'(LINE_END);
  localparam logic [8:0] WRAP_X  = 9'h1FF;

  // Per-line latched scroll/magnify
  logic [SCROLL_W-1:0] scroll_q;
  logic                mag_q;

  // Per-dot fetch context
  logic [ADR_W-1:0]    adr_q;
  logic                sel_q;
  logic                active_q;
  logic                last_q;
  logic                we_q;

  // Registered mixer outputs
  logic                color_out_q;
  logic [COLOR_W-1:0]  color_code_q;
  logic                cc_flag_q;
  logic                display_en_q;

  // Pixel index arithmetic
  logic [DIF_W+8:0]        x_wide;
  logic [DIF_W+SCROLL_W-1:0] scroll_wide;
  logic [DIF_W-1:0]        x_ext;
  logic [DIF_W-1:0]        scroll_ext;
  logic [DIF_W-1:0]        diff;
  logic [PIX_W-1:0]        pix;
  logic                    active_c;
  logic                    last_c;
  logic [COLOR_W+1:0]      entry;

  always_comb begin
    x_wide      = {{DIF_W{1'b0}}, dot_counter_x};
    scroll_wide = {{DIF_W{1'b0}}, scroll_q};
    x_ext       = x_wide[DIF_W-1:0];
    scroll_ext  = scroll_wide[DIF_W-1:0];
    // Modular subtraction: a scroll larger than X lands at the top of the buffer.
    diff        = x_ext - scroll_ext;
    pix         = mag_q ? diff[DIF_W-1:1] : diff[PIX_W-1:0];
    // The wrap dot 1FF and the blanking dots fall out of this compare.
    active_c    = ({1'b0, dot_counter_x} < H_ACT_X) && ({1'b0, dot_counter_x} <= LAST_X);
    // A word is finished after its odd pixel; in magnify mode only on the
    // second of the two dots that show that odd pixel.
    last_c      = pix[0] & (~mag_q | diff[0]);
  end

  always_comb begin
    entry = sel_q ? lb.line_buffer_xodd_q : lb.line_buffer_xeven_q;
  end

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      scroll_q     <= '0;
      mag_q        <= 1'b0;
      adr_q        <= '0;
      sel_q        <= 1'b0;
      active_q     <= 1'b0;
      last_q       <= 1'b0;
      we_q         <= 1'b0;
      color_out_q  <= 1'b0;
      color_code_q <= '0;
      cc_flag_q    <= 1'b0;
      display_en_q <= 1'b0;
    end else begin
      // The clear strobe lives for the single ERASE clock only.
      we_q <= 1'b0;
      case (dot_state)
        PH_FETCH: begin
          adr_q    <= pix[PIX_W-1:1];
          sel_q    <= pix[0];
          active_q <= active_c;
          last_q   <= last_c;
          if (dot_counter_x == WRAP_X) begin
            scroll_q <= reg_h_scroll;
            mag_q    <= reg_sp_mag_x;
          end
        end
        PH_READ: begin
          // Line buffer is producing q for adr_q during this clock.
        end
        PH_SHOW: begin
          if (active_q) begin
            color_code_q <= entry[COLOR_W-1:0];
            cc_flag_q    <= entry[COLOR_W];
            color_out_q  <= entry[COLOR_W+1] & ~reg_sp_disable;
            display_en_q <= 1'b1;
          end else begin
            color_code_q <= '0;
            cc_flag_q    <= 1'b0;
            color_out_q  <= 1'b0;
            display_en_q <= 1'b0;
          end
          // Registered here so the strobe covers exactly the following ERASE clock.
          we_q <= active_q & reg_erase_en & last_q;
        end
        PH_ERASE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign lb.line_buffer_display_adr = adr_q;
  assign lb.line_buffer_display_we  = we_q;
  assign lb.line_buffer_display_d   = '0;

  assign sp_color_out  = color_out_q;
  assign sp_color_code = color_code_q;
  assign sp_cc_flag    = cc_flag_q;
  assign sp_display_en = display_en_q;

endmodule
